mips16_mem_arbiter: RTL
=======================

# mips16_mem_arbiter

Single-port memory arbiter and stall controller for the MIPS16 core. It shares one synchronous memory port between the instruction-fetch requester (IF) and the load/store requester (DM). It sequences each access through a small FSM that is aware of memory read latency. It drives the per-requester ack and stall signals that freeze the pipeline while a port is waiting. It sits between the MIPS16 datapath and the unified instruction/data RAM.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 1, memory read latency in cycles (≥1); mem_rdata is valid MEM_LAT cycles after the mem_en cycle
- STARVE_MAX, 4, maximum consecutive DM grants while if_req is pending (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request (level)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word
- if_ack  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_ack
- dm_req  in  1  data request (level)
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data
- dm_ack  out  1  one-cycle data completion pulse
- dm_stall  out  1  dm_req & ~dm_ack
- mem_en  out  1  memory access strobe, one cycle per grant
- mem_we  out  1  memory write enable (valid with mem_en)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states:
  - IDLE: may grant.
  - WAIT: a read is outstanding; a counter runs 1..MEM_LAT.
  - RESP: presents the ack; may grant in the same cycle.
- Grant decision (IDLE or RESP):
  - If dm_req and starve count < STARVE_MAX, grant DM.
  - Otherwise, if if_req, grant IF.
  - Otherwise, grant DM if dm_req.
- Grant cycle: mem_en=1, and mem_addr/mem_we/mem_wdata come from the granted port.
  - IF grant: mem_we=0.
  - DM grant: mem_we=dm_we, and mem_wdata=dm_wdata on stores.
- Next state after a grant:
  - Read grant: WAIT.
  - Write grant: RESP, with dm_ack asserted in the following cycle.
  - No grant from RESP: IDLE.
- WAIT: at the end of cycle G+MEM_LAT, mem_rdata is registered into the granted port's rdata register, and the FSM moves to RESP.
- RESP: the granted port's ack=1 for exactly one cycle.
  - rdata holds its value until that port's next read completes.
  - The other port's rdata is unchanged.
- Starve counter:
  - Increments on each DM grant while if_req=1.
  - Clears on any IF grant, or in any cycle with if_req=0.
  - Saturates at STARVE_MAX.
- Requester contract:
  - Hold req, addr, we and wdata stable from assertion until the ack cycle.
  - In the ack cycle, req is either deasserted or carries the next request, which may be granted in that same cycle.
  - A req dropped before its grant is simply not served; dropping req after grant is illegal.
- At most one transaction is outstanding; mem_en never pulses while in WAIT.
- Reset:
  - All outputs 0 (if_rdata and dm_rdata = 0), state IDLE, starve count 0.
  - Asserting reset mid-WAIT abandons the read; no ack is produced.

## Timing
- Read: grant in cycle G, ack and rdata valid in cycle G+MEM_LAT+1.
  - Back-to-back reads: one per MEM_LAT+1 cycles.
- Write: grant in cycle G, dm_ack in cycle G+1.
  - Back-to-back writes: one per cycle after the first.
- Grant-to-mem_en latency is 0: the grant is combinational from req in IDLE/RESP, and mem_* outputs are combinational from the selected port.
- ack outputs are registered; stall outputs are combinational from req and the registered ack.
- Simultaneous if_req and dm_req with count < STARVE_MAX: DM wins; IF stalls.
- Reset dominates every other event in its cycle.

## Test plan
- Single fetch, MEM_LAT=1: if_req=1 with if_addr=0x0010 at cycle 0; memory returns 0x1234.
  - Required: mem_en=1 and mem_addr=0x0010 in cycle 0; if_ack=1 and if_rdata=0x1234 in cycle 2; if_stall=1 in cycles 0–1.
- Store then load:
  - Store: dm_we=1, addr 0x0020, data 0xBEEF; required mem_we=1 in cycle 0 and dm_ack in cycle 1.
  - Load: same address, issued in cycle 1; required dm_rdata=0xBEEF with dm_ack in cycle 3.
- Conflict: if_req and dm_req both asserted in cycle 0 (DM load).
  - Required: DM granted in cycle 0, dm_ack in cycle 2, IF granted in cycle 2, if_ack in cycle 4.
- Starvation, STARVE_MAX=4: dm_req held with a new store every ack cycle, if_req held.
  - Required: exactly 4 consecutive DM grants, then an IF grant, then DM resumes.
- Reset mid-read, MEM_LAT=3: reset asserted in cycle G+2.
  - Required: no ack; all outputs 0 from the next cycle; a new fetch after reset completes normally.
- Idle: no requests.
  - Required: mem_en, acks and stalls remain 0 indefinitely.

Source files
------------

// File: rtl/mips16_mem_arbiter.sv
// Single-port memory arbiter for the MIPS16 core: shares one synchronous RAM between
// instruction fetch and load/store, sequencing reads by latency and driving stalls.
module mips16_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_if, grant_dm;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;

    // DM has priority until it has starved a waiting fetch STARVE_MAX times in a row
    if (!reset && (state_q == IDLE || state_q == RESP)) begin
      if (dm_req && (!if_req || starve_q < STV_W'(STARVE_MAX))) begin
        grant_dm = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end

    case (state_q)
      IDLE, RESP: begin
        if (grant_dm && dm_we) begin
          state_d  = RESP;
          owner_d  = 1'b1;
          dm_ack_d = 1'b1;
        end else if (grant_dm || grant_if) begin
          state_d = WAIT;
          owner_d = grant_dm;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(MEM_LAT)) begin
          state_d = RESP;
          if (owner_q) begin
            dm_rdata_d = mem_rdata;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_dm && starve_q < STV_W'(STARVE_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      starve_q   <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en    = grant_if | grant_dm;
  assign mem_we    = grant_dm & dm_we;
  assign mem_addr  = grant_dm ? dm_addr : (grant_if ? if_addr : '0);
  assign mem_wdata = (grant_dm && dm_we) ? dm_wdata : '0;

  assign if_ack   = if_ack_q;
  assign dm_ack   = dm_ack_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign if_stall = if_req & ~if_ack_q;
  assign dm_stall = dm_req & ~dm_ack_q;

endmodule
